// File: rtl/pong_pkg.sv
// pong_pkg: shared state type, direction constants and screen geometry
// for the Pong rally referee and its paddle hit detectors.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } pong_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SCREEN_W = 640;
    localparam int COORD_W  = 10;
    // One extra bit so edge + size never wraps at 1023.
    localparam int SUM_W    = COORD_W + 1;

    // Score increment that sticks at the 4-bit ceiling.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// pong_paddle_hit: combinational ball/paddle overlap and goal-line test
// for one side of the court. SIDE selects which paddle face is guarded.
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter logic SIDE        = DIR_LEFT,
    parameter int   PAD_W       = 4,
    parameter int   PAD_H       = 48,
    parameter int   GOAL_MARGIN = 2
) (
    input  logic [COORD_W-1:0] x_ball,
    input  logic [COORD_W-1:0] y_ball,
    input  logic               x_ball_dir,
    input  logic [4:0]         width_ball,
    input  logic [4:0]         height_ball,
    input  logic [COORD_W-1:0] x_pad,
    input  logic [COORD_W-1:0] y_pad,
    output logic               hit,
    output logic               miss
);

    logic [SUM_W-1:0] xb, yb, xp, yp;
    logic [SUM_W-1:0] ball_right, ball_bottom, pad_right, pad_bottom;
    logic             toward, x_overlap, y_overlap, past;

    // Overlap of the ball box with the paddle box, gated by approach direction.
    always_comb begin
        xb          = SUM_W'(x_ball);
        yb          = SUM_W'(y_ball);
        xp          = SUM_W'(x_pad);
        yp          = SUM_W'(y_pad);
        ball_right  = xb + SUM_W'(width_ball);
        ball_bottom = yb + SUM_W'(height_ball);
        pad_right   = xp + SUM_W'(PAD_W);
        pad_bottom  = yp + SUM_W'(PAD_H);

        toward    = (x_ball_dir == SIDE);
        x_overlap = (xb <= pad_right) && (ball_right >= xp);
        y_overlap = (ball_bottom >= yp) && (yb <= pad_bottom);
        hit       = toward && x_overlap && y_overlap;

        if (SIDE == DIR_LEFT) begin
            past = (xb + SUM_W'(GOAL_MARGIN)) < xp;
        end else begin
            past = xb > (pad_right + SUM_W'(GOAL_MARGIN));
        end
        miss = toward && !hit && past;
    end

endmodule

// File: rtl/pong_rally_referee.sv
// pong_rally_referee: decides paddle hits and misses, runs the serve
// handshake to the ball controller, keeps both scores and the winner.
// Optional rally speed-up is enabled by defining PONG_SPEEDUP_EN.
module pong_rally_referee
    import pong_pkg::*;
#(
    parameter int PAD_W       = 4,
    parameter int PAD_H       = 48,
    parameter int GOAL_MARGIN = 2,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 9,
    parameter int BASE_VEL    = 2,
    parameter int MAX_VEL     = 7
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x_ball,
    input  logic [COORD_W-1:0] y_ball,
    input  logic               x_ball_dir,
    input  logic [4:0]         width_ball,
    input  logic [4:0]         height_ball,
    input  logic [COORD_W-1:0] x_lpad,
    input  logic [COORD_W-1:0] y_lpad,
    input  logic [COORD_W-1:0] x_rpad,
    input  logic [COORD_W-1:0] y_rpad,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               bounce_x,
    output logic [3:0]         x_ball_vel,
    output logic [3:0]         score_l,
    output logic [3:0]         score_r,
    output logic               game_over,
    output logic               winner
);

    localparam int               CNT_W      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [3:0]       WIN_LIMIT  = 4'(WIN_SCORE);
    localparam logic [3:0]       MAX_V      = 4'(MAX_VEL);
    // Starting velocity never exceeds the ceiling.
    localparam logic [3:0]       VEL_START  = (4'(BASE_VEL) > MAX_V) ? MAX_V : 4'(BASE_VEL);

    pong_state_e      state, state_next;
    logic [CNT_W-1:0] serve_cnt, serve_cnt_next;
    logic             arm_l, arm_r, arm_l_next, arm_r_next;
    logic             scorer_r, scorer_r_next;
    logic             hit_l_raw, hit_r_raw, miss_l, miss_r;
    logic             hit_l, hit_r;
    logic             ball_reset_next, serve_dir_next, bounce_next;
    logic             game_over_next, winner_next;
    logic [3:0]       score_l_next, score_r_next, score_inc;

    pong_paddle_hit #(
        .SIDE        (DIR_LEFT),
        .PAD_W       (PAD_W),
        .PAD_H       (PAD_H),
        .GOAL_MARGIN (GOAL_MARGIN)
    ) u_hit_l (
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .x_ball_dir  (x_ball_dir),
        .width_ball  (width_ball),
        .height_ball (height_ball),
        .x_pad       (x_lpad),
        .y_pad       (y_lpad),
        .hit         (hit_l_raw),
        .miss        (miss_l)
    );

    pong_paddle_hit #(
        .SIDE        (DIR_RIGHT),
        .PAD_W       (PAD_W),
        .PAD_H       (PAD_H),
        .GOAL_MARGIN (GOAL_MARGIN)
    ) u_hit_r (
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .x_ball_dir  (x_ball_dir),
        .width_ball  (width_ball),
        .height_ball (height_ball),
        .x_pad       (x_rpad),
        .y_pad       (y_rpad),
        .hit         (hit_r_raw),
        .miss        (miss_r)
    );

    // Arming and the previous pulse both block a hit, so pulses never touch.
    assign hit_l     = hit_l_raw && !arm_l && !bounce_x;
    assign hit_r     = hit_r_raw && !arm_r && !bounce_x;
    assign score_inc = sat_inc4(scorer_r ? score_r : score_l);

    // State register.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SERVE;
            SERVE:   if (serve_cnt == '0) state_next = PLAY;
            PLAY:    if (miss_l || miss_r) state_next = POINT;
            POINT:   state_next = (score_inc == WIN_LIMIT) ? OVER : SERVE;
            OVER:    if (start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and rally bookkeeping.
    always_comb begin
        serve_cnt_next  = serve_cnt;
        arm_l_next      = arm_l;
        arm_r_next      = arm_r;
        scorer_r_next   = scorer_r;
        serve_dir_next  = serve_dir;
        bounce_next     = 1'b0;
        score_l_next    = score_l;
        score_r_next    = score_r;
        winner_next     = winner;
        ball_reset_next = (state_next != PLAY);
        game_over_next  = (state_next == OVER);

        unique case (state)
            IDLE: begin
                if (start) serve_cnt_next = SERVE_LOAD;
            end
            SERVE: begin
                arm_l_next = 1'b0;
                arm_r_next = 1'b0;
                if (serve_cnt != '0) serve_cnt_next = serve_cnt - CNT_W'(1);
            end
            PLAY: begin
                bounce_next = hit_l || hit_r;
                if (hit_l) arm_l_next = 1'b1;
                else if (x_ball_dir != DIR_LEFT) arm_l_next = 1'b0;
                if (hit_r) arm_r_next = 1'b1;
                else if (x_ball_dir != DIR_RIGHT) arm_r_next = 1'b0;
                if (miss_l) scorer_r_next = 1'b1;
                else if (miss_r) scorer_r_next = 1'b0;
            end
            POINT: begin
                arm_l_next = 1'b0;
                arm_r_next = 1'b0;
                if (scorer_r) score_r_next = score_inc;
                else score_l_next = score_inc;
                // Serve goes toward whoever conceded.
                serve_dir_next = scorer_r ? DIR_LEFT : DIR_RIGHT;
                if (state_next == OVER) winner_next = scorer_r;
                else serve_cnt_next = SERVE_LOAD;
            end
            OVER: begin
            end
            default: begin
            end
        endcase

        if (state_next == IDLE) begin
            score_l_next = '0;
            score_r_next = '0;
        end
    end

    // Output and bookkeeping registers.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            serve_cnt  <= '0;
            arm_l      <= 1'b0;
            arm_r      <= 1'b0;
            scorer_r   <= 1'b0;
            ball_reset <= 1'b1;
            serve_dir  <= DIR_RIGHT;
            bounce_x   <= 1'b0;
            score_l    <= '0;
            score_r    <= '0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
        end else begin
            serve_cnt  <= serve_cnt_next;
            arm_l      <= arm_l_next;
            arm_r      <= arm_r_next;
            scorer_r   <= scorer_r_next;
            ball_reset <= ball_reset_next;
            serve_dir  <= serve_dir_next;
            bounce_x   <= bounce_next;
            score_l    <= score_l_next;
            score_r    <= score_r_next;
            game_over  <= game_over_next;
            winner     <= winner_next;
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [1:0] rally_cnt, rally_cnt_next;
    logic [3:0] vel_next;

    // Every fourth bounce raises the velocity; a point or idle restores it.
    always_comb begin
        rally_cnt_next = rally_cnt;
        vel_next       = x_ball_vel;
        if (state == PLAY && bounce_next) begin
            rally_cnt_next = rally_cnt + 2'd1;
            if (rally_cnt == 2'd3 && x_ball_vel < MAX_V) vel_next = x_ball_vel + 4'd1;
        end
        if (state == POINT || state == IDLE) begin
            rally_cnt_next = '0;
            vel_next       = VEL_START;
        end
    end

    // Rally counter and velocity registers.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            rally_cnt  <= '0;
            x_ball_vel <= VEL_START;
        end else begin
            rally_cnt  <= rally_cnt_next;
            x_ball_vel <= vel_next;
        end
    end
`else
    assign x_ball_vel = VEL_START;
`endif

endmodule

// File: tb/tb_pong_rally_referee.sv
// tb_pong_rally_referee: directed scenarios followed by random play,
// every output compared each tick against a behavioural referee model.
module tb_pong_rally_referee;

    localparam int PAD_W       = 4;
    localparam int PAD_H       = 48;
    localparam int GOAL_MARGIN = 2;
    localparam int SERVE_TICKS = 60;
    localparam int WIN_SCORE   = 9;
    localparam int BASE_VEL    = 2;
    localparam int MAX_VEL     = 7;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic       game_clk = 1'b0;
    logic       reset, start;
    logic [9:0] x_ball, y_ball, x_lpad, y_lpad, x_rpad, y_rpad;
    logic       x_ball_dir;
    logic [4:0] width_ball, height_ball;
    logic       ball_reset, serve_dir, bounce_x, game_over, winner;
    logic [3:0] x_ball_vel, score_l, score_r;

    always #5 game_clk = ~game_clk;

    pong_rally_referee #(
        .PAD_W       (PAD_W),
        .PAD_H       (PAD_H),
        .GOAL_MARGIN (GOAL_MARGIN),
        .SERVE_TICKS (SERVE_TICKS),
        .WIN_SCORE   (WIN_SCORE),
        .BASE_VEL    (BASE_VEL),
        .MAX_VEL     (MAX_VEL)
    ) dut (
        .game_clk    (game_clk),
        .reset       (reset),
        .start       (start),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .x_ball_dir  (x_ball_dir),
        .width_ball  (width_ball),
        .height_ball (height_ball),
        .x_lpad      (x_lpad),
        .y_lpad      (y_lpad),
        .x_rpad      (x_rpad),
        .y_rpad      (y_rpad),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .bounce_x    (bounce_x),
        .x_ball_vel  (x_ball_vel),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_over   (game_over),
        .winner      (winner)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: game phase, ticks left on the serve hold, plain-int scores.
    int m_phase, m_hold, m_sl, m_sr, m_dir, m_bounce, m_vel, m_win;
    int m_arm_l, m_arm_r, m_hits, m_right_scored;

    function automatic int vel_floor();
        return (BASE_VEL > MAX_VEL) ? MAX_VEL : BASE_VEL;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_hold = 0; m_sl = 0; m_sr = 0; m_dir = 1;
        m_bounce = 0; m_vel = vel_floor(); m_win = 0;
        m_arm_l = 0; m_arm_r = 0; m_hits = 0; m_right_scored = 0;
    endtask

    task automatic model_step();
        int xb, yb, w, h, xl, yl, xr, yr, prev, s;
        bit hl, hr, ml, mr;
        if (reset) begin
            model_reset();
            return;
        end
        xb = int'(x_ball); yb = int'(y_ball); w = int'(width_ball); h = int'(height_ball);
        xl = int'(x_lpad); yl = int'(y_lpad); xr = int'(x_rpad); yr = int'(y_rpad);
        prev = m_bounce;
        m_bounce = 0;
        case (m_phase)
            M_IDLE: begin
                m_vel = vel_floor(); m_hits = 0;
                if (start) begin m_phase = M_SERVE; m_hold = SERVE_TICKS; end
            end
            M_SERVE: begin
                m_arm_l = 0; m_arm_r = 0;
                m_hold--;
                if (m_hold == 0) m_phase = M_PLAY;
            end
            M_PLAY: begin
                hl = (x_ball_dir == 1'b0) && xb <= xl + PAD_W && xb + w >= xl && yb + h >= yl && yb <= yl + PAD_H;
                hr = (x_ball_dir == 1'b1) && xb + w >= xr && xb <= xr + PAD_W && yb + h >= yr && yb <= yr + PAD_H;
                ml = (x_ball_dir == 1'b0) && !hl && xb + GOAL_MARGIN < xl;
                mr = (x_ball_dir == 1'b1) && !hr && xb > xr + PAD_W + GOAL_MARGIN;
                if (x_ball_dir) m_arm_l = 0; else m_arm_r = 0;
                if (prev == 0 && ((hl && m_arm_l == 0) || (hr && m_arm_r == 0))) begin
                    m_bounce = 1;
                    if (hl) m_arm_l = 1; else m_arm_r = 1;
`ifdef PONG_SPEEDUP_EN
                    m_hits++;
                    if (m_hits % 4 == 0 && m_vel < MAX_VEL) m_vel++;
`endif
                end
                if (ml) begin m_phase = M_POINT; m_right_scored = 1; end
                else if (mr) begin m_phase = M_POINT; m_right_scored = 0; end
            end
            M_POINT: begin
                m_arm_l = 0; m_arm_r = 0; m_hits = 0; m_vel = vel_floor();
                if (m_right_scored) begin
                    m_sr = (m_sr < 15) ? m_sr + 1 : 15; s = m_sr; m_dir = 0;
                end else begin
                    m_sl = (m_sl < 15) ? m_sl + 1 : 15; s = m_sl; m_dir = 1;
                end
                if (s == WIN_SCORE) begin m_phase = M_OVER; m_win = m_right_scored; end
                else begin m_phase = M_SERVE; m_hold = SERVE_TICKS; end
            end
            default: begin
                if (start) begin m_phase = M_IDLE; m_sl = 0; m_sr = 0; end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("ball_reset", ball_reset, (m_phase != M_PLAY) ? 1 : 0);
        check_eq("serve_dir", serve_dir, m_dir);
        check_eq("bounce_x", bounce_x, m_bounce);
        check_eq("x_ball_vel", x_ball_vel, m_vel);
        check_eq("score_l", score_l, m_sl);
        check_eq("score_r", score_r, m_sr);
        check_eq("game_over", game_over, (m_phase == M_OVER) ? 1 : 0);
        check_eq("winner", winner, m_win);
    endtask

    task automatic tick();
        model_step();
        @(posedge game_clk);
        #1;
        compare_all();
    endtask

    task automatic set_ball(input int x, input int y, input int dir);
        x_ball = 10'(x); y_ball = 10'(y); x_ball_dir = dir[0];
    endtask

    task automatic park_ball();
        set_ball(300, 240, 0);
    endtask

    task automatic left_miss_point();
        set_ball(10, 400, 0);
        tick();
        park_ball();
        repeat (SERVE_TICKS + 1) tick();
    endtask

    task automatic drive_random();
        int r, ysel;
        r = $urandom_range(0, 99);
        x_lpad = 10'($urandom_range(8, 40));
        x_rpad = 10'($urandom_range(580, 630));
        y_lpad = 10'($urandom_range(0, 430));
        y_rpad = 10'($urandom_range(0, 430));
        width_ball = 5'($urandom_range(1, 31));
        height_ball = 5'($urandom_range(1, 31));
        x_ball_dir = 1'($urandom_range(0, 1));
        if (r < 60) x_ball = 10'($urandom_range(100, 500));
        else if (r < 77) x_ball = 10'($urandom_range(0, int'(x_lpad) + PAD_W + 4));
        else if (r < 94) x_ball = 10'($urandom_range(int'(x_rpad) - 31, int'(x_rpad) + PAD_W + 8));
        else x_ball = 10'($urandom_range(990, 1023));
        ysel = x_ball_dir ? int'(y_rpad) : int'(y_lpad);
        if ($urandom_range(0, 1) == 1) y_ball = 10'(ysel + int'($urandom_range(0, 50)));
        else y_ball = 10'($urandom_range(0, 1023));
        start = ($urandom_range(0, 39) == 0);
        reset = ($urandom_range(0, 1999) == 0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; start = 1'b0;
        park_ball();
        width_ball = 5'd8; height_ball = 5'd8;
        x_lpad = 10'd20; y_lpad = 10'd200; x_rpad = 10'd600; y_rpad = 10'd200;

        // Reset, start, serve hold.
        repeat (2) tick();
        reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (SERVE_TICKS - 1) tick();
        check_eq("serve_hold_last", ball_reset, 1);
        tick();
        check_eq("serve_release", ball_reset, 0);
        check_eq("serve_dir_first", serve_dir, 1);

        // Left hit, then held against the paddle.
        set_ball(22, 210, 0);
        tick();
        check_eq("left_hit_pulse", bounce_x, 1);
        repeat (5) tick();
        check_eq("left_hit_once", bounce_x, 0);

        // Alternating hits for the rally counter.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) set_ball(598, 210, 1);
            else set_ball(22, 210, 0);
            tick();
            park_ball();
            tick();
        end

        // Nine left misses end the game.
        for (int k = 0; k < WIN_SCORE; k++) begin
            left_miss_point();
            if (k == 0) check_eq("first_miss_dir", serve_dir, 0);
        end
        check_eq("final_score_r", score_r, WIN_SCORE);
        check_eq("final_over", game_over, 1);
        check_eq("final_winner", winner, 1);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("restart_score_r", score_r, 0);
        check_eq("restart_over", game_over, 0);

        // Reset in the middle of a serve.
        start = 1'b1; tick(); start = 1'b0;
        repeat (29) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("midserve_ball_reset", ball_reset, 1);
        check_eq("midserve_bounce", bounce_x, 0);
        check_eq("midserve_score_l", score_l, 0);

        // Random play.
        for (int t = 0; t < 20000; t++) begin
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
